gpio_reg_arbiter: RTL and testbench

//  - Shares one GPIO_register_ip between two bus requesters (m0 = CPU, m1 = pattern/DMA engine).
//  - Uses a 2-way round-robin grant and a one-transaction-at-a-time FSM.
//  - Drives the IP en/wr/addr_offset/data_in pins and returns data_out to the winning requester.
//  - Rejects illegal offsets without touching the IP.

---
 rtl/gpio_reg_pkg.sv | 26 ++
 rtl/gpio_reg_arbiter_arb.sv | 15 +
 rtl/gpio_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_gpio_reg_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_reg_pkg.sv
// Shared offsets, FSM state encoding and offset legality check for the GPIO register arbiter.
package gpio_reg_pkg;

    localparam logic [7:0] GPIO_DATA_OFF = 8'h00;
    localparam logic [7:0] GPIO_DIR_OFF  = 8'h04;
    localparam logic [7:0] GPIO_READ_OFF = 8'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // READ is an input-pin snapshot, so writing it is rejected like an unknown offset.
    function automatic logic offset_legal(input logic we, input logic [7:0] addr);
        logic ok;
        case (addr)
            GPIO_DATA_OFF, GPIO_DIR_OFF: ok = 1'b1;
            GPIO_READ_OFF:               ok = ~we;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/gpio_reg_arbiter_arb.sv
// Two-way round-robin grant: on contention the requester that did not win last time is picked.
module gpio_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Shares one GPIO register IP between a CPU (m0) and a pattern/DMA engine (m1),
// one transaction at a time, with round-robin arbitration and offset checking.
//
//  state | meaning
//  IDLE  | arbitrate, latch the winner, reject illegal offsets straight to RESP
//  ISSUE | one cycle of gpio_en with the latched address/data
//  WAIT  | read only: hold en for RD_LAT cycles, capture data_out on the last one
//  RESP  | one-cycle ack (and err) to the granted requester
module gpio_reg_arbiter
    import gpio_reg_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        gpio_en,
    output logic        gpio_wr,
    output logic [7:0]  gpio_addr_offset,
    output logic [31:0] gpio_data_in,
    input  logic [31:0] gpio_data_out
);

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t      state;
    logic        last_grant;
    logic        lat_we;
    logic        lat_gnt;
    logic [1:0]  wait_cnt;
    logic [1:0]  grant;
    logic        sel_m1;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    gpio_rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_m1    = grant[1];
    assign req_we    = sel_m1 ? m1_we    : m0_we;
    assign req_addr  = sel_m1 ? m1_addr  : m0_addr;
    assign req_wdata = sel_m1 ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            lat_we           <= 1'b0;
            lat_gnt          <= 1'b0;
            wait_cnt         <= 2'd0;
            m0_ack           <= 1'b0;
            m0_err           <= 1'b0;
            m0_rdata         <= 32'h0;
            m1_ack           <= 1'b0;
            m1_err           <= 1'b0;
            m1_rdata         <= 32'h0;
            gpio_en          <= 1'b0;
            gpio_wr          <= 1'b0;
            gpio_addr_offset <= 8'h0;
            gpio_data_in     <= 32'h0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        lat_gnt    <= sel_m1;
                        lat_we     <= req_we;
                        last_grant <= sel_m1;
                        if (offset_legal(req_we, req_addr)) begin
                            state            <= ISSUE;
                            gpio_en          <= 1'b1;
                            gpio_wr          <= req_we;
                            gpio_addr_offset <= req_addr;
                            gpio_data_in     <= req_wdata;
                        end else begin
                            state  <= RESP;
                            m0_ack <= ~sel_m1;
                            m0_err <= ~sel_m1;
                            m1_ack <= sel_m1;
                            m1_err <= sel_m1;
                        end
                    end
                end
                ISSUE: begin
                    gpio_wr <= 1'b0;
                    if (lat_we) begin
                        state   <= RESP;
                        gpio_en <= 1'b0;
                        m0_ack  <= ~lat_gnt;
                        m1_ack  <= lat_gnt;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    // Down-counter reaching zero marks the cycle the IP data is valid.
                    if (wait_cnt == 2'd0) begin
                        state   <= RESP;
                        gpio_en <= 1'b0;
                        m0_ack  <= ~lat_gnt;
                        m1_ack  <= lat_gnt;
                        if (lat_gnt) begin
                            m1_rdata <= gpio_data_out;
                        end else begin
                            m0_rdata <= gpio_data_out;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed bench: vector table of single-requester transactions plus contention,
// mid-read reset and an RD_LAT=3 instance, against a small behavioural GPIO IP model.
module tb_gpio_reg_arbiter;

    localparam logic [31:0] READ_PINS = 32'h1357_9BDF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        gpio_en, gpio_wr;
    logic [7:0]  gpio_addr_offset;
    logic [31:0] gpio_data_in, gpio_data_out;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m0_err;
    logic [7:0]  b_m0_addr;
    logic [31:0] b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_ack, b_m1_err;
    logic [7:0]  b_m1_addr;
    logic [31:0] b_m1_wdata, b_m1_rdata;
    logic        b_gpio_en, b_gpio_wr;
    logic [7:0]  b_gpio_addr_offset;
    logic [31:0] b_gpio_data_in, b_gpio_data_out;

    gpio_reg_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .gpio_en(gpio_en), .gpio_wr(gpio_wr), .gpio_addr_offset(gpio_addr_offset),
        .gpio_data_in(gpio_data_in), .gpio_data_out(gpio_data_out)
    );

    gpio_reg_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
        .gpio_en(b_gpio_en), .gpio_wr(b_gpio_wr), .gpio_addr_offset(b_gpio_addr_offset),
        .gpio_data_in(b_gpio_data_in), .gpio_data_out(b_gpio_data_out)
    );

    // Behavioural IP: registers written on en&wr, reads return data RD_LAT cycles after the issue cycle.
    function automatic logic [31:0] ip_lookup(input logic [7:0] a, input logic [31:0] d,
                                              input logic [31:0] r);
        case (a)
            8'h00:   return d;
            8'h04:   return r;
            8'h08:   return READ_PINS;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [31:0] ip_data = 32'h0, ip_dir = 32'h0, ip_pipe = 32'h0;
    always @(posedge clk) begin
        if (gpio_en && gpio_wr && gpio_addr_offset == 8'h00) ip_data <= gpio_data_in;
        if (gpio_en && gpio_wr && gpio_addr_offset == 8'h04) ip_dir  <= gpio_data_in;
        ip_pipe <= (gpio_en && !gpio_wr) ? ip_lookup(gpio_addr_offset, ip_data, ip_dir) : 32'h0;
    end
    assign gpio_data_out = ip_pipe;

    logic [31:0] b_data = 32'h0, b_dir = 32'h0, b_p0 = 32'h0, b_p1 = 32'h0, b_p2 = 32'h0;
    always @(posedge clk) begin
        if (b_gpio_en && b_gpio_wr && b_gpio_addr_offset == 8'h00) b_data <= b_gpio_data_in;
        if (b_gpio_en && b_gpio_wr && b_gpio_addr_offset == 8'h04) b_dir  <= b_gpio_data_in;
        b_p0 <= (b_gpio_en && !b_gpio_wr) ? ip_lookup(b_gpio_addr_offset, b_data, b_dir) : 32'h0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_gpio_data_out = b_p2;

    // Bus monitors; expected address/data are written only by the stimulus tasks.
    logic [7:0]  mon_addr = 8'h0;
    logic [31:0] mon_wdata = 32'h0;
    int en_cnt = 0, wr_cnt = 0, gpio_bad = 0, b_en_cnt = 0;
    always @(negedge clk) begin
        if (gpio_en) en_cnt <= en_cnt + 1;
        if (gpio_en && gpio_wr) wr_cnt <= wr_cnt + 1;
        if ((gpio_en && gpio_addr_offset != mon_addr) || (gpio_wr && !gpio_en) ||
            (gpio_en && gpio_wr && gpio_data_in != mon_wdata))
            gpio_bad <= gpio_bad + 1;
        if (b_gpio_en) b_en_cnt <= b_en_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        m;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          en;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_vec(input vec_t v, input string tag);
        int lat = -1;
        int e0, w0, g0;
        logic err = 1'b0, other = 1'b0;
        logic [31:0] rd = 32'h0;
        @(negedge clk);
        mon_addr = v.addr; mon_wdata = v.wdata;
        e0 = en_cnt; w0 = wr_cnt; g0 = gpio_bad;
        if (v.m) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (v.m ? m0_ack : m1_ack) other = 1'b1;
            if (v.m ? m1_ack : m0_ack) begin
                lat = k;
                err = v.m ? m1_err : m0_err;
                rd  = v.m ? m1_rdata : m0_rdata;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check({tag, " ack latency"}, 32'(lat), 32'(v.lat));
        check({tag, " err"}, 32'(err), 32'(v.err));
        if (v.chk) check({tag, " rdata"}, rd, v.rdata);
        check({tag, " gpio_en cycles"}, 32'(en_cnt - e0), 32'(v.en));
        check({tag, " gpio_wr cycles"}, 32'(wr_cnt - w0), (v.we && v.en != 0) ? 32'd1 : 32'd0);
        check({tag, " gpio addr/data"}, 32'(gpio_bad - g0), 32'd0);
        check({tag, " other ack"}, 32'(other), 32'd0);
    endtask

    task automatic run_both(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input int el0, input int el1, input logic [31:0] ed0,
                            input logic [31:0] ed1);
        int l0 = -1, l1 = -1;
        logic [31:0] d0 = 32'h0, d1 = 32'h0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = a0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = a1; m1_wdata = 32'h0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (m0_ack && l0 < 0) begin l0 = k; d0 = m0_rdata; m0_req = 1'b0; end
            if (m1_ack && l1 < 0) begin l1 = k; d1 = m1_rdata; m1_req = 1'b0; end
            if (l0 >= 0 && l1 >= 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check({tag, " m0 ack cycle"}, 32'(l0), 32'(el0));
        check({tag, " m1 ack cycle"}, 32'(l1), 32'(el1));
        check({tag, " m0 rdata"}, d0, ed0);
        check({tag, " m1 rdata"}, d1, ed1);
    endtask

    task automatic b_txn(input string tag, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input int el, input int een,
                         input logic chk, input logic [31:0] ed);
        int lat = -1;
        int e0;
        logic [31:0] rd = 32'h0;
        @(negedge clk);
        e0 = b_en_cnt;
        b_m0_req = 1'b1; b_m0_we = we; b_m0_addr = addr; b_m0_wdata = wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_m0_ack) begin lat = k; rd = b_m0_rdata; break; end
        end
        b_m0_req = 1'b0;
        check({tag, " ack latency"}, 32'(lat), 32'(el));
        check({tag, " gpio_en cycles"}, 32'(b_en_cnt - e0), 32'(een));
        if (chk) check({tag, " rdata"}, rd, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           m     we    addr   wdata          lat err   chk   rdata          en
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 32'hA5A5A5A5, 2, 1'b0, 1'b0, 32'h0,         1};
        vecs[1]  = '{1'b0, 1'b1, 8'h04, 32'hFFFFFFF0, 2, 1'b0, 1'b0, 32'h0,         1};
        vecs[2]  = '{1'b0, 1'b0, 8'h04, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFFFF0, 2};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 32'h0,        3, 1'b0, 1'b1, 32'hA5A5A5A5, 2};
        vecs[4]  = '{1'b0, 1'b0, 8'h08, 32'h0,        3, 1'b0, 1'b1, READ_PINS,     2};
        vecs[5]  = '{1'b1, 1'b1, 8'h08, 32'h1,        1, 1'b1, 1'b0, 32'h0,         0};
        vecs[6]  = '{1'b1, 1'b0, 8'h0C, 32'h0,        1, 1'b1, 1'b0, 32'h0,         0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 32'h0,        3, 1'b0, 1'b1, 32'hA5A5A5A5, 2};
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 32'h12345678, 2, 1'b0, 1'b0, 32'h0,         1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 32'h0,        3, 1'b0, 1'b1, 32'h12345678, 2};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 32'h0,        1, 1'b1, 1'b0, 32'h0,         0};
        vecs[11] = '{1'b1, 1'b0, 8'h05, 32'h0,        1, 1'b1, 1'b0, 32'h0,         0};

        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h0; m1_wdata = 32'h0;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 8'h0; b_m0_wdata = 32'h0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 8'h0; b_m1_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset m0_ack", 32'(m0_ack), 32'd0);
        check("reset m1_ack", 32'(m1_ack), 32'd0);
        check("reset gpio_en", 32'(gpio_en), 32'd0);
        check("reset gpio_wr", 32'(gpio_wr), 32'd0);
        check("reset m0_rdata", m0_rdata, 32'h0);
        check("reset gpio_addr_offset", 32'(gpio_addr_offset), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Last grant was m1 (vec11), so m0 wins, then alternation keeps m0 first.
        run_both("contend1", 8'h04, 8'h00, 3, 7, 32'hFFFFFFF0, 32'h12345678);
        run_both("contend2", 8'h08, 8'h04, 3, 7, READ_PINS, 32'hFFFFFFF0);
        apply_vec('{1'b0, 1'b0, 8'h00, 32'h0, 3, 1'b0, 1'b1, 32'h12345678, 2}, "m0 solo");
        run_both("contend3", 8'h04, 8'h08, 7, 3, 32'hFFFFFFF0, READ_PINS);

        // m0 read aborted by reset during WAIT.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h04;
        @(negedge clk);
        check("abort issue gpio_en", 32'(gpio_en), 32'd1);
        @(negedge clk);
        check("abort wait m0_ack", 32'(m0_ack), 32'd0);
        rst = 1'b1; m0_req = 1'b0;
        @(negedge clk);
        check("abort m0_ack", 32'(m0_ack), 32'd0);
        check("abort gpio_en", 32'(gpio_en), 32'd0);
        check("abort m0_rdata cleared", m0_rdata, 32'h0);
        check("abort gpio_addr_offset", 32'(gpio_addr_offset), 32'h0);
        rst = 1'b0;
        run_both("post-reset", 8'h00, 8'h04, 3, 7, 32'h12345678, 32'hFFFFFFF0);

        b_txn("rdlat3 wr", 1'b1, 8'h00, 32'h0F0F0F0F, 2, 1, 1'b0, 32'h0);
        b_txn("rdlat3 rd08", 1'b0, 8'h08, 32'h0, 5, 4, 1'b1, READ_PINS);
        b_txn("rdlat3 rd00", 1'b0, 8'h00, 32'h0, 5, 4, 1'b1, 32'h0F0F0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
